// File: rtl/music_sched.sv
// Melody sequencer: walks a song's notes through a synchronous melody ROM and
// hands each note code to a tone player, with play/pause, stop and song selection.
`timescale 1ns/1ps
module music_sched #(
  parameter int NUM_SONGS = 3,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_play,
  input  logic              cmd_stop,
  input  logic              cmd_next,
  input  logic              cmd_prev,
  input  logic              loop_en,
  output logic [1:0]        song_sel,
  input  logic [ADDR_W-1:0] song_len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [5:0]        rom_data,
  output logic [5:0]        note_code,
  output logic              note_valid,
  input  logic              note_ready,
  input  logic              note_done,
  output logic              note_abort,
  output logic              song_done,
  output logic              playing,
  output logic [2:0]        dbg_state
);

  // Handshake: a note transfers on the cycle where note_valid & note_ready are
  // both high; note_code is held stable from ISSUE entry until that cycle.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LOAD      = 3'd2,
    ISSUE     = 3'd3,
    WAIT_DONE = 3'd4,
    PAUSED    = 3'd5
  } state_t;

  localparam logic [1:0] LAST_SONG = 2'(NUM_SONGS - 1);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   note_idx, note_idx_nx;
  logic [1:0]          song_sel_nx;
  logic [5:0]          note_code_nx;
  logic                pause_pend, pause_pend_nx;
  logic                abort_nx, done_nx;
  logic                sel_one, in_note, last_note, pause_eff;

  assign sel_one    = cmd_next ^ cmd_prev;
  assign in_note    = (state == ISSUE) || (state == WAIT_DONE);
  assign last_note  = (note_idx == song_len - ADDR_W'(1));
  assign playing    = (state == FETCH) || (state == LOAD) || in_note;
  assign note_valid = (state == ISSUE);
  assign rom_addr   = note_idx;
  assign dbg_state  = state;

  always_comb begin
    state_nx      = state;
    note_idx_nx   = note_idx;
    song_sel_nx   = song_sel;
    note_code_nx  = note_code;
    pause_pend_nx = pause_pend;
    abort_nx      = 1'b0;
    done_nx       = 1'b0;
    pause_eff     = pause_pend ^ cmd_play;

    if (state == LOAD) note_code_nx = rom_data;

    if (cmd_stop) begin
      if (state != IDLE) begin
        state_nx      = IDLE;
        note_idx_nx   = '0;
        pause_pend_nx = 1'b0;
        abort_nx      = in_note;
      end
    end else if (sel_one) begin
      if (cmd_next) song_sel_nx = (song_sel == LAST_SONG) ? 2'd0 : song_sel + 2'd1;
      else          song_sel_nx = (song_sel == 2'd0) ? LAST_SONG : song_sel - 2'd1;
      note_idx_nx   = '0;
      pause_pend_nx = 1'b0;
      // A running song restarts on the new selection; an idle/paused one just reselects.
      if (playing) begin
        abort_nx = in_note;
        state_nx = FETCH;
      end else begin
        state_nx = IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (cmd_play) begin
            if (song_len != '0) state_nx = FETCH;
            else                done_nx  = 1'b1;
          end
        end
        FETCH: begin
          state_nx = LOAD;
          if (cmd_play) pause_pend_nx = ~pause_pend;
        end
        LOAD: begin
          state_nx = ISSUE;
          if (cmd_play) pause_pend_nx = ~pause_pend;
        end
        ISSUE: begin
          if (note_ready) state_nx = WAIT_DONE;
          if (cmd_play) pause_pend_nx = ~pause_pend;
        end
        WAIT_DONE: begin
          pause_pend_nx = pause_eff;
          if (note_done) begin
            pause_pend_nx = 1'b0;
            if (!last_note) begin
              note_idx_nx = note_idx + ADDR_W'(1);
              state_nx    = pause_eff ? PAUSED : FETCH;
            end else if (loop_en) begin
              note_idx_nx = '0;
              state_nx    = pause_eff ? PAUSED : FETCH;
            end else begin
              note_idx_nx = '0;
              done_nx     = 1'b1;
              state_nx    = IDLE;
            end
          end
        end
        PAUSED: begin
          if (cmd_play) state_nx = FETCH;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      note_idx   <= '0;
      song_sel   <= 2'd0;
      note_code  <= 6'd0;
      pause_pend <= 1'b0;
      note_abort <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      note_idx   <= note_idx_nx;
      song_sel   <= song_sel_nx;
      note_code  <= note_code_nx;
      pause_pend <= pause_pend_nx;
      note_abort <= abort_nx;
      song_done  <= done_nx;
    end
  end

endmodule

// File: doc/music_sched.md
MUSIC_SCHED -- requirements
Module: music_sched

Interface
REQ-001 Parameter NUM_SONGS, default 3, number of selectable melodies (2..4).
REQ-002 Parameter ADDR_W, default 8, width of note index and ROM address.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 cmd_play  input  1  one-cycle pulse; toggles play/pause.
REQ-006 cmd_stop  input  1  one-cycle pulse; stops and rewinds the current song.
REQ-007 cmd_next  input  1  one-cycle pulse; advances to the next song.
REQ-008 cmd_prev  input  1  one-cycle pulse; returns to the previous song.
REQ-009 loop_en  input  1  level; 1 = restart the song at its end.
REQ-010 song_sel  output  2  current song index, 0..NUM_SONGS-1.
REQ-011 song_len  input  ADDR_W  note count of song_sel, combinational from song_sel.
REQ-012 rom_addr  output  ADDR_W  note index presented to the melody ROM.
REQ-013 rom_data  input  6  6-bit note code, valid exactly one cycle after rom_addr is stable.
REQ-014 note_code  output  6  note code for the tone player.
REQ-015 note_valid  output  1  note_code offered to the player.
REQ-016 note_ready  input  1  player accepts note_code when note_valid & note_ready.
REQ-017 note_done  input  1  one-cycle pulse when the player finishes the accepted note.
REQ-018 note_abort  output  1  one-cycle pulse telling the player to silence immediately.
REQ-019 song_done  output  1  one-cycle pulse at a non-looping song end.
REQ-020 playing  output  1  high in FETCH, LOAD, ISSUE and WAIT_DONE.

Function
REQ-021 FSM states: IDLE, FETCH, LOAD, ISSUE, WAIT_DONE, PAUSED.
REQ-022 IDLE: cmd_play with song_len>0 -> FETCH; with song_len==0 -> pulse song_done, stay IDLE.
REQ-023 FETCH: rom_addr=note_idx, -> LOAD next cycle; LOAD: register rom_data into note_code, -> ISSUE.
REQ-024 ISSUE: note_valid=1 and note_code held stable until the note_ready cycle; then -> WAIT_DONE.
REQ-025 WAIT_DONE on note_done: not last note -> note_idx+1, FETCH; last note (note_idx==song_len-1) with loop_en -> note_idx=0, FETCH; else -> song_done pulse, note_idx=0, IDLE.
REQ-026 cmd_play while playing sets pause_pend; pause takes effect at the next note boundary (note_done), entering PAUSED with note_idx already advanced; a second cmd_play before then clears pause_pend.
REQ-027 PAUSED: cmd_play -> FETCH, resuming at note_idx.
REQ-028 cmd_stop in any non-IDLE state: note_abort pulse if in ISSUE or WAIT_DONE, note_idx=0, pause_pend=0, -> IDLE next cycle.
REQ-029 cmd_next: song_sel+1 wrapping NUM_SONGS-1 -> 0; cmd_prev: song_sel-1 wrapping 0 -> NUM_SONGS-1; both reset note_idx=0.
REQ-030 next/prev while playing: note_abort pulse if in ISSUE or WAIT_DONE, then FETCH of note 0 of the new song; in IDLE or PAUSED: select only, state -> IDLE.
REQ-031 Command priority in one cycle: cmd_stop > (cmd_next xor cmd_prev) > cmd_play; cmd_next and cmd_prev together are ignored.
REQ-032 A note_done arriving in the same cycle as an abort is discarded.
REQ-033 note_valid is low outside ISSUE; note_abort and song_done are never high for more than one cycle.
REQ-034 Commands are sampled every cycle, including during LOAD, and take effect the following cycle.

Reset
REQ-035 While rst=1: state IDLE, song_sel=0, note_idx=0, rom_addr=0, note_code=0, pause_pend=0, all pulse outputs and note_valid low, playing=0.
REQ-036 After rst deassertion, no note is issued until a cmd_play.

Verification
REQ-037 song_len=3, ROM codes 8,9,10, player acks 1 cycle after valid, done 5 cycles later -> codes 8,9,10 issued in order, song_done once, IDLE.
REQ-038 Same song with loop_en=1 -> fourth issued code is 8, no song_done.
REQ-039 cmd_play during WAIT_DONE of note 1 -> PAUSED after that note_done; cmd_play -> next issued code is note 2's.
REQ-040 song_sel=NUM_SONGS-1, cmd_next during WAIT_DONE -> note_abort one cycle, song_sel=0, note 0 fetched.
REQ-041 cmd_stop and cmd_next in the same cycle -> IDLE, song_sel unchanged, note_idx=0.
REQ-042 rst asserted mid-ISSUE -> note_valid low immediately, all outputs at reset values.
